adffe_piso: RTL and testbench

- Reader/unload end for an enable-gated capture register. Takes a WIDTH-bit word on a load strobe and drains it one bit per accepted beat over a valid/ready serial interface.
- Sits downstream of the load-enable flop stages in the flipFlops test family. Exercises async reset, enable gating, an FSM, a counter and handshake stalls in a single block.

---
 rtl/adffe_piso.sv | 51 +++++
 tb/tb_adffe_piso.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adffe_piso.sv
// adffe_piso: enable-gated parallel word capture, drained one bit per beat over a valid/ready serial link
module adffe_piso #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic             READY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             SLAST,
    input  logic             SREADY
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    // capture on load in IDLE, shift toward the output end on each accepted beat, return to IDLE after the last
    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (EN) begin
                shreg <= D;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (SREADY) begin
            if (SLAST) begin
                state <= IDLE;
            end else begin
                shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    assign READY  = state == IDLE;
    assign SVALID = state == SHIFT;
    assign SLAST  = SVALID && cnt == CW'(WIDTH - 1);
    assign SOUT   = SVALID ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
endmodule

// File: tb/tb_adffe_piso.sv
// tb_adffe_piso: directed checks of MSB-first, LSB-first and single-bit serialiser instances
module tb_adffe_piso;
    logic       CLK = 1'b0;
    logic       ARST = 1'b0;
    int         tests = 0;
    int         fails = 0;

    logic       en_m = 1'b0, sready_m = 1'b1;
    logic [7:0] d_m = '0;
    logic       ready_m, sout_m, svalid_m, slast_m;

    logic       en_l = 1'b0, sready_l = 1'b1;
    logic [7:0] d_l = '0;
    logic       ready_l, sout_l, svalid_l, slast_l;

    logic       en_1 = 1'b0, sready_1 = 1'b1;
    logic [0:0] d_1 = '0;
    logic       ready_1, sout_1, svalid_1, slast_1;

    adffe_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .CLK(CLK), .ARST(ARST), .EN(en_m), .D(d_m), .READY(ready_m),
        .SOUT(sout_m), .SVALID(svalid_m), .SLAST(slast_m), .SREADY(sready_m)
    );

    adffe_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .CLK(CLK), .ARST(ARST), .EN(en_l), .D(d_l), .READY(ready_l),
        .SOUT(sout_l), .SVALID(svalid_l), .SLAST(slast_l), .SREADY(sready_l)
    );

    adffe_piso #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
        .CLK(CLK), .ARST(ARST), .EN(en_1), .D(d_1), .READY(ready_1),
        .SOUT(sout_1), .SVALID(svalid_1), .SLAST(slast_1), .SREADY(sready_1)
    );

    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        cycle();
        ARST = 1'b1;
        cycle();
        en_m = 1'b1; d_m = 8'h5A; sready_m = 1'b0;
        cycle();
        en_m = 1'b0;
        tests++;
        if (svalid_m !== 1'b1) begin fails++; $display("FAIL reset_preload svalid=%b want 1", svalid_m); end
        #2;
        en_m = 1'b1; d_m = 8'hFF;
        ARST = 1'b0;
        #1;
        tests++;
        if ({ready_m, svalid_m, sout_m, slast_m} !== 4'b1000)
            begin fails++; $display("FAIL reset_async {ready,svalid,sout,slast}=%b want 1000", {ready_m, svalid_m, sout_m, slast_m}); end
        cycle();
        cycle();
        tests++;
        if ({ready_m, svalid_m, sout_m, slast_m} !== 4'b1000)
            begin fails++; $display("FAIL reset_hold {ready,svalid,sout,slast}=%b want 1000", {ready_m, svalid_m, sout_m, slast_m}); end
        en_m = 1'b0; sready_m = 1'b1;
        #2;
        ARST = 1'b1;
        cycle();
        tests++;
        if ({ready_m, svalid_m} !== 2'b10) begin fails++; $display("FAIL reset_release {ready,svalid}=%b want 10", {ready_m, svalid_m}); end
    endtask

    task automatic test_msb_drain();
        logic [7:0] w;
        w = 8'hA5;
        sready_m = 1'b1;
        en_m = 1'b1; d_m = w;
        cycle();
        en_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({svalid_m, ready_m, sout_m, slast_m} !== {1'b1, 1'b0, w[7-i], i == 7})
                begin fails++; $display("FAIL msb_beat%0d {svalid,ready,sout,slast}=%b want %b", i, {svalid_m, ready_m, sout_m, slast_m}, {1'b1, 1'b0, w[7-i], i == 7}); end
            cycle();
        end
        tests++;
        if ({ready_m, svalid_m, sout_m, slast_m} !== 4'b1000)
            begin fails++; $display("FAIL msb_done {ready,svalid,sout,slast}=%b want 1000", {ready_m, svalid_m, sout_m, slast_m}); end
    endtask

    task automatic test_lsb_stall();
        logic [7:0] w;
        int n;
        w = 8'h0F;
        n = 0;
        sready_l = 1'b1;
        en_l = 1'b1; d_l = w;
        cycle();
        en_l = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == 1 || b == 4) begin
                sready_l = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tests++;
                    if ({svalid_l, sout_l, slast_l} !== {1'b1, w[b], 1'b0})
                        begin fails++; $display("FAIL lsb_stall b%0d s%0d {svalid,sout,slast}=%b want %b", b, s, {svalid_l, sout_l, slast_l}, {1'b1, w[b], 1'b0}); end
                    n += int'(svalid_l);
                    cycle();
                end
                sready_l = 1'b1;
            end
            tests++;
            if ({svalid_l, sout_l, slast_l} !== {1'b1, w[b], b == 7})
                begin fails++; $display("FAIL lsb_beat%0d {svalid,sout,slast}=%b want %b", b, {svalid_l, sout_l, slast_l}, {1'b1, w[b], b == 7}); end
            n += int'(svalid_l);
            cycle();
        end
        tests++;
        if (n !== 14) begin fails++; $display("FAIL lsb_shift_cycles got %0d want 14", n); end
        tests++;
        if ({ready_l, svalid_l} !== 2'b10) begin fails++; $display("FAIL lsb_done {ready,svalid}=%b want 10", {ready_l, svalid_l}); end
    endtask

    task automatic test_ignored_load();
        logic [7:0] w;
        w = 8'h3C;
        sready_m = 1'b1;
        en_m = 1'b1; d_m = w;
        cycle();
        en_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin en_m = 1'b1; d_m = 8'hFF; end
            else en_m = 1'b0;
            tests++;
            if ({svalid_m, sout_m, slast_m} !== {1'b1, w[7-i], i == 7})
                begin fails++; $display("FAIL ign_beat%0d {svalid,sout,slast}=%b want %b", i, {svalid_m, sout_m, slast_m}, {1'b1, w[7-i], i == 7}); end
            cycle();
        end
        en_m = 1'b0;
        cycle();
        tests++;
        if ({ready_m, svalid_m} !== 2'b10) begin fails++; $display("FAIL ign_idle {ready,svalid}=%b want 10", {ready_m, svalid_m}); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        w = 8'hC3;
        sready_m = 1'b1;
        en_m = 1'b1; d_m = w;
        cycle();
        en_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({svalid_m, sout_m} !== {1'b1, w[7-i]})
                begin fails++; $display("FAIL mid_beat%0d {svalid,sout}=%b want %b", i, {svalid_m, sout_m}, {1'b1, w[7-i]}); end
            cycle();
        end
        #2;
        ARST = 1'b0;
        #1;
        tests++;
        if ({ready_m, svalid_m, slast_m} !== 3'b100)
            begin fails++; $display("FAIL mid_abort {ready,svalid,slast}=%b want 100", {ready_m, svalid_m, slast_m}); end
        cycle();
        #2;
        ARST = 1'b1;
        cycle();
        w = 8'h81;
        en_m = 1'b1; d_m = w;
        cycle();
        en_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({svalid_m, sout_m, slast_m} !== {1'b1, w[7-i], i == 7})
                begin fails++; $display("FAIL post_beat%0d {svalid,sout,slast}=%b want %b", i, {svalid_m, sout_m, slast_m}, {1'b1, w[7-i], i == 7}); end
            cycle();
        end
        tests++;
        if ({ready_m, svalid_m} !== 2'b10) begin fails++; $display("FAIL post_done {ready,svalid}=%b want 10", {ready_m, svalid_m}); end
    endtask

    task automatic test_width1();
        sready_1 = 1'b1;
        en_1 = 1'b1; d_1 = 1'b1;
        cycle();
        en_1 = 1'b0;
        tests++;
        if ({ready_1, svalid_1, slast_1, sout_1} !== 4'b0111)
            begin fails++; $display("FAIL w1_beat {ready,svalid,slast,sout}=%b want 0111", {ready_1, svalid_1, slast_1, sout_1}); end
        cycle();
        tests++;
        if ({ready_1, svalid_1, slast_1, sout_1} !== 4'b1000)
            begin fails++; $display("FAIL w1_done {ready,svalid,slast,sout}=%b want 1000", {ready_1, svalid_1, slast_1, sout_1}); end
        sready_1 = 1'b0;
        en_1 = 1'b1; d_1 = 1'b1;
        cycle();
        en_1 = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tests++;
            if ({ready_1, svalid_1, slast_1, sout_1} !== 4'b0111)
                begin fails++; $display("FAIL w1_stall%0d {ready,svalid,slast,sout}=%b want 0111", s, {ready_1, svalid_1, slast_1, sout_1}); end
            cycle();
        end
        sready_1 = 1'b1;
        cycle();
        tests++;
        if ({ready_1, svalid_1} !== 2'b10) begin fails++; $display("FAIL w1_release {ready,svalid}=%b want 10", {ready_1, svalid_1}); end
    endtask

    initial begin
        test_reset();
        test_msb_drain();
        test_lsb_stall();
        test_ignored_load();
        test_reset_midword();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
